move_validator: RTL

Collision responder for the player-movement FSM. It answers the start/done request that the top level issues once per update tick. On each request it computes the candidate player rectangle after a one-pixel step, checks it against the 8x8 map bounds, and scans every map cell the rectangle overlaps. It then returns a registered verdict on `move_is_valid`.

---
 rtl/move_validator_if.sv | 25 ++
 rtl/move_validator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_validator_if.sv
// Request/verdict bundle between the player-movement FSM (master) and the
// collision responder (slave).
interface move_validator_if;
    logic         start;
    logic [0:127] grid_color;
    logic [9:0]   x_pos;
    logic [9:0]   y_pos;
    logic [9:0]   width;
    logic [9:0]   height;
    logic [1:0]   l_r;
    logic [1:0]   u_d;
    logic         done;
    logic         move_is_valid;
    logic         busy;

    modport master (
        output start, grid_color, x_pos, y_pos, width, height, l_r, u_d,
        input  done, move_is_valid, busy
    );

    modport slave (
        input  start, grid_color, x_pos, y_pos, width, height, l_r, u_d,
        output done, move_is_valid, busy
    );
endinterface

// File: rtl/move_validator.sv
// Collision responder: steps the player rectangle one pixel, bounds-checks it
// against the 8x8 map and scans every overlapped cell for walls.
module move_validator #(
    parameter int CELL_SIZE = 60,
    parameter int GRID_X0   = 80,
    parameter int GRID_Y0   = 0
) (
    input logic             clk,
    input logic             rst,
    move_validator_if.slave bus
);

    localparam logic signed [11:0] X_MIN = 12'(GRID_X0);
    localparam logic signed [11:0] Y_MIN = 12'(GRID_Y0);
    localparam logic signed [11:0] X_MAX = 12'(GRID_X0 + 8 * CELL_SIZE - 1);
    localparam logic signed [11:0] Y_MAX = 12'(GRID_Y0 + 8 * CELL_SIZE - 1);
    localparam logic [9:0]         CS    = 10'(CELL_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_BOUNDS,
        S_DIVIDE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [0:127] grid_q;
    logic [9:0]   x_q;
    logic [9:0]   y_q;
    logic [9:0]   w_q;
    logic [9:0]   h_q;
    logic [1:0]   lr_q;
    logic [1:0]   ud_q;

    logic signed [11:0] nx;
    logic signed [11:0] ny;
    logic signed [11:0] ex;
    logic signed [11:0] ey;
    logic signed [11:0] nx_calc;
    logic signed [11:0] ny_calc;
    logic signed [11:0] ex_calc;
    logic signed [11:0] ey_calc;

    logic [9:0] div_c0;
    logic [9:0] div_c1;
    logic [9:0] div_r0;
    logic [9:0] div_r1;
    logic [2:0] q_c0;
    logic [2:0] q_c1;
    logic [2:0] q_r0;
    logic [2:0] q_r1;

    logic [2:0] row;
    logic [2:0] col;

    logic done_q;
    logic valid_q;

    logic       out_of_bounds;
    logic       ge_c0;
    logic       ge_c1;
    logic       ge_r0;
    logic       ge_r1;
    logic       any_ge;
    logic [5:0] cell_idx;
    logic [1:0] cell_code;
    logic       last_cell;
    logic       verdict_load;
    logic       verdict_value;

    // One-pixel step in each axis; 0 and 3 leave the coordinate unchanged.
    always_comb begin
        nx_calc = $signed({2'b00, x_q});
        ny_calc = $signed({2'b00, y_q});
        if (lr_q == 2'd1) begin
            nx_calc = $signed({2'b00, x_q}) + 12'sd1;
        end else if (lr_q == 2'd2) begin
            nx_calc = $signed({2'b00, x_q}) - 12'sd1;
        end
        if (ud_q == 2'd1) begin
            ny_calc = $signed({2'b00, y_q}) + 12'sd1;
        end else if (ud_q == 2'd2) begin
            ny_calc = $signed({2'b00, y_q}) - 12'sd1;
        end
        ex_calc = nx_calc + $signed({2'b00, w_q}) - 12'sd1;
        ey_calc = ny_calc + $signed({2'b00, h_q}) - 12'sd1;
    end

    assign out_of_bounds = (nx < X_MIN) || (ny < Y_MIN) ||
                           (ex > X_MAX) || (ey > Y_MAX) ||
                           (w_q == 10'd0) || (h_q == 10'd0);

    assign ge_c0  = (div_c0 >= CS);
    assign ge_c1  = (div_c1 >= CS);
    assign ge_r0  = (div_r0 >= CS);
    assign ge_r1  = (div_r1 >= CS);
    assign any_ge = ge_c0 || ge_c1 || ge_r0 || ge_r1;

    // Cell i occupies map bits 2i (msb) and 2i+1 (lsb).
    assign cell_idx  = {row, col};
    assign cell_code = {grid_q[{cell_idx, 1'b0}], grid_q[{cell_idx, 1'b1}]};
    assign last_cell = (row == q_r1) && (col == q_c1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        verdict_load  = 1'b0;
        verdict_value = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    next_state = S_LATCH;
                end
            end
            S_LATCH: begin
                next_state = S_BOUNDS;
            end
            S_BOUNDS: begin
                if (out_of_bounds) begin
                    next_state    = S_DONE;
                    verdict_load  = 1'b1;
                    verdict_value = 1'b0;
                end else begin
                    next_state = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (!any_ge) begin
                    next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cell_code != 2'd0) begin
                    next_state    = S_DONE;
                    verdict_load  = 1'b1;
                    verdict_value = 1'b0;
                end else if (last_cell) begin
                    next_state    = S_DONE;
                    verdict_load  = 1'b1;
                    verdict_value = 1'b1;
                end
            end
            S_DONE: begin
                if (!bus.start) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: the request is snapshotted in IDLE so later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grid_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            lr_q    <= '0;
            ud_q    <= '0;
            nx      <= '0;
            ny      <= '0;
            ex      <= '0;
            ey      <= '0;
            div_c0  <= '0;
            div_c1  <= '0;
            div_r0  <= '0;
            div_r1  <= '0;
            q_c0    <= '0;
            q_c1    <= '0;
            q_r0    <= '0;
            q_r1    <= '0;
            row     <= '0;
            col     <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        grid_q <= bus.grid_color;
                        x_q    <= bus.x_pos;
                        y_q    <= bus.y_pos;
                        w_q    <= bus.width;
                        h_q    <= bus.height;
                        lr_q   <= bus.l_r;
                        ud_q   <= bus.u_d;
                    end
                end
                S_LATCH: begin
                    nx <= nx_calc;
                    ny <= ny_calc;
                    ex <= ex_calc;
                    ey <= ey_calc;
                end
                S_BOUNDS: begin
                    if (!out_of_bounds) begin
                        div_c0 <= 10'(nx - X_MIN);
                        div_c1 <= 10'(ex - X_MIN);
                        div_r0 <= 10'(ny - Y_MIN);
                        div_r1 <= 10'(ey - Y_MIN);
                        q_c0   <= '0;
                        q_c1   <= '0;
                        q_r0   <= '0;
                        q_r1   <= '0;
                    end
                end
                S_DIVIDE: begin
                    if (any_ge) begin
                        if (ge_c0) begin
                            div_c0 <= div_c0 - CS;
                            q_c0   <= q_c0 + 3'd1;
                        end
                        if (ge_c1) begin
                            div_c1 <= div_c1 - CS;
                            q_c1   <= q_c1 + 3'd1;
                        end
                        if (ge_r0) begin
                            div_r0 <= div_r0 - CS;
                            q_r0   <= q_r0 + 3'd1;
                        end
                        if (ge_r1) begin
                            div_r1 <= div_r1 - CS;
                            q_r1   <= q_r1 + 3'd1;
                        end
                    end else begin
                        row <= q_r0;
                        col <= q_c0;
                    end
                end
                S_SCAN: begin
                    if (cell_code == 2'd0 && !last_cell) begin
                        if (col == q_c1) begin
                            col <= q_c0;
                            row <= row + 3'd1;
                        end else begin
                            col <= col + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase

            done_q <= (next_state == S_DONE);
            if (verdict_load) begin
                valid_q <= verdict_value;
            end
        end
    end

    assign bus.done          = done_q;
    assign bus.move_is_valid = valid_q;
    assign bus.busy          = (state != S_IDLE);

endmodule
